// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int unsigned UART_DATA_BITS           = 8;
  localparam int unsigned UART_DEFAULT_CLK_PER_BIT = 868;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with a separately tracked occupancy count and combinational head.
module byte_fifo #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic [CW-1:0]    count,
  output logic             full_c,
  output logic             empty_c
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign push_ok = push && !full_c;
  assign pop_ok  = pop && !empty_c;
  assign head_c  = mem[rd_ptr];

  // Storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_unit.sv
// 8N1 UART transmitter fed by a valid/ready byte handshake through a small FIFO.
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter  int unsigned CLK_PER_BIT = UART_DEFAULT_CLK_PER_BIT,
  parameter  int unsigned FIFO_DEPTH  = 16,
  localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [UART_DATA_BITS-1:0] uart_in_data,
  input  logic                      uart_in_valid,
  output logic                      uart_in_ready,
  output logic                      txd,
  output logic                      busy,
  output logic [CW-1:0]             fifo_count
);

  localparam int unsigned BW = $clog2(CLK_PER_BIT);
  localparam int unsigned IW = $clog2(UART_DATA_BITS);

  uart_tx_state_t            state;
  logic [BW-1:0]             baud;
  logic [IW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] head_c;
  logic                      full_c;
  logic                      empty_c;
  logic                      accept_c;
  logic                      pop_c;
  logic                      last_c;

  // !uart_in_ready keeps a still-held valid from pushing the same byte twice.
  assign accept_c = uart_in_valid && !uart_in_ready && !full_c;
  assign pop_c    = (state == IDLE) && !empty_c;
  assign last_c   = (baud == BW'(CLK_PER_BIT - 1));

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept_c),
    .wdata   (uart_in_data),
    .pop     (pop_c),
    .head_c  (head_c),
    .count   (fifo_count),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // txd follows the state one cycle late, so every frame spans exactly 10 bit times.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      baud          <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      txd           <= 1'b1;
      busy          <= 1'b0;
      uart_in_ready <= 1'b0;
    end else begin
      uart_in_ready <= accept_c;
      busy          <= (fifo_count != '0) || (state != IDLE);
      unique case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop_c) begin
            shift <= head_c;
            baud  <= '0;
            state <= START;
          end
        end
        START: begin
          txd <= 1'b0;
          if (last_c) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          txd <= shift[0];
          if (last_c) begin
            baud  <= '0;
            shift <= shift >> 1;
            if (bit_idx == IW'(UART_DATA_BITS - 1)) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          txd <= 1'b1;
          if (last_c) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + BW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit: line-level frame decoder plus per-scenario tasks.
module tb_uart_tx_unit;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int          FRAME = 10 * CPB;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          valid = 1'b0;
  logic [7:0]    data  = 8'h00;
  logic          ready;
  logic          txd;
  logic          busy;
  logic [CW-1:0] fifo_count;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int ready_cnt = 0;
  int peak      = 0;
  bit mon_en    = 1'b1;

  logic [8:0] rx_q[$];
  int         rx_start[$];

  uart_tx_unit #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_in_data  (data),
    .uart_in_valid (valid),
    .uart_in_ready (ready),
    .txd           (txd),
    .busy          (busy),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ready === 1'b1) ready_cnt++;
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  end

  // Line decoder: detect start bit, sample each bit at its centre, record {stop, byte}.
  initial forever begin
    @(negedge clk);
    if (txd === 1'b0 && reset === 1'b0) begin
      int         s;
      logic [7:0] b;
      logic       st;
      s = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = txd;
      end
      repeat (CPB) @(negedge clk);
      st = txd;
      if (mon_en) begin
        rx_q.push_back({st, b});
        rx_start.push_back(s);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Expected line level k cycles into a frame carrying d (outside the frame: idle high).
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    int b;
    if (k < 0 || k >= FRAME) return 1'b1;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  task automatic push_byte(input logic [7:0] d, input bit hold, output int acc);
    int n = 0;
    data  = d;
    valid = 1'b1;
    acc   = -1;
    while (acc < 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (ready === 1'b1) acc = cyc;
    end
    checks++;
    if (acc < 0) begin
      failures++;
      $display("FAIL push_timeout byte=%h no ready within %0d cycles", d, n);
    end
    if (hold) begin
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (rx_q.size() < n && t < n * (FRAME + 2) + 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (rx_q.size() < n) begin
      failures++;
      $display("FAIL wait_frames got=%0d want=%0d", rx_q.size(), n);
    end
  endtask

  task automatic check_rx(input string name, input logic [7:0] d);
    logic [8:0] got;
    got = 9'h000;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    checks++;
    if (got !== {1'b1, d}) begin
      failures++;
      $display("FAIL %s got={stop,byte}=%h want=%h", name, got, {1'b1, d});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({txd, busy, ready, fifo_count} !== {1'b1, 1'b0, 1'b0, CW'(0)}) begin
      failures++;
      $display("FAIL reset_values txd=%b busy=%b ready=%b count=%0d want 1,0,0,0",
               txd, busy, ready, fifo_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({txd, busy, ready, fifo_count} !== {1'b1, 1'b0, 1'b0, CW'(0)}) begin
        failures++;
        $display("FAIL idle_cycle%0d txd=%b busy=%b ready=%b count=%0d want 1,0,0,0",
                 i, txd, busy, ready, fifo_count);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] d;
    int         acc, r0;
    logic       et, eb;
    d  = 8'hA5;
    rx_q.delete();
    rx_start.delete();
    r0   = ready_cnt;
    peak = 0;
    push_byte(d, 1'b0, acc);
    for (int j = 1; j <= FRAME + 6; j++) begin
      @(negedge clk);
      et = frame_bit(d, j - 2);
      eb = (j < FRAME + 2);
      checks++;
      if (txd !== et || busy !== eb) begin
        failures++;
        $display("FAIL single_wave j=%0d txd=%b busy=%b want txd=%b busy=%b", j, txd, busy, et, eb);
      end
    end
    checks++;
    if (ready_cnt - r0 != 1) begin
      failures++;
      $display("FAIL single_ready_pulses got=%0d want=1", ready_cnt - r0);
    end
    checks++;
    if (peak != 1) begin
      failures++;
      $display("FAIL single_peak_count got=%0d want=1", peak);
    end
    wait_frames(1);
    check_rx("single_decode", d);
  endtask

  task automatic test_hold_valid();
    logic [7:0] d;
    int         acc, r0;
    d = 8'($urandom);
    rx_q.delete();
    rx_start.delete();
    r0   = ready_cnt;
    peak = 0;
    push_byte(d, 1'b1, acc);
    wait_frames(1);
    repeat (2 * FRAME) @(negedge clk);
    checks++;
    if (ready_cnt - r0 != 1 || peak != 1 || rx_q.size() != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_no_dup pulses=%0d peak=%0d frames=%0d busy=%b want 1,1,1,0",
               ready_cnt - r0, peak, rx_q.size(), busy);
    end
    check_rx("hold_decode", d);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [18];
    int         acc   [18];
    rx_q.delete();
    rx_start.delete();
    peak = 0;
    for (int i = 0; i < 18; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 18; i++) push_byte(bytes[i], 1'b0, acc[i]);
    // 17 accepts fill the FIFO; the 18th waits for the second pop, one frame plus idle after the first.
    checks++;
    if (peak != int'(DEPTH)) begin
      failures++;
      $display("FAIL b2b_peak got=%0d want=%0d", peak, DEPTH);
    end
    checks++;
    if (acc[17] - acc[0] != FRAME + 3) begin
      failures++;
      $display("FAIL b2b_stall_resume got=%0d want=%0d", acc[17] - acc[0], FRAME + 3);
    end
    wait_frames(18);
    for (int i = 1; i < 18 && i < rx_start.size(); i++) begin
      checks++;
      if (rx_start[i] - rx_start[i-1] != FRAME + 1) begin
        failures++;
        $display("FAIL b2b_gap%0d got=%0d want=%0d", i, rx_start[i] - rx_start[i-1], FRAME + 1);
      end
    end
    for (int i = 0; i < 18; i++) check_rx($sformatf("b2b_byte%0d", i), bytes[i]);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int         a0, acc, bad;
    d = 8'h3C;
    rx_q.delete();
    rx_start.delete();
    push_byte(d, 1'b0, a0);
    for (int i = 0; i < 5; i++) push_byte(8'($urandom), 1'b0, acc);
    // Middle of data bit 3: frame offset (1+3)*CPB + CPB/2, line lags accept by 2.
    while (cyc < a0 + 2 + 4 * CPB + CPB / 2) @(negedge clk);
    checks++;
    if (fifo_count !== CW'(5) || txd !== d[3]) begin
      failures++;
      $display("FAIL midframe_pre count=%0d txd=%b want 5,%b", fifo_count, txd, d[3]);
    end
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    checks++;
    if ({txd, busy, ready, fifo_count} !== {1'b1, 1'b0, 1'b0, CW'(0)}) begin
      failures++;
      $display("FAIL midframe_async txd=%b busy=%b ready=%b count=%0d want 1,0,0,0",
               txd, busy, ready, fifo_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad   = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_count !== CW'(0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midframe_quiet active_cycles=%0d want 0", bad);
    end
    rx_q.delete();
    rx_start.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_simultaneous();
    logic [7:0] x;
    int         ax, a11;
    x = 8'($urandom);
    rx_q.delete();
    rx_start.delete();
    push_byte(x, 1'b0, ax);
    push_byte(8'h11, 1'b0, a11);
    // The IDLE pop of 0x11 lands one frame plus one cycle after x's pop (ax+1).
    while (cyc < ax + FRAME + 1) @(negedge clk);
    checks++;
    if (fifo_count !== CW'(1)) begin
      failures++;
      $display("FAIL simul_pre count=%0d want 1", fifo_count);
    end
    data  = 8'h55;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if (ready !== 1'b1 || fifo_count !== CW'(1)) begin
      failures++;
      $display("FAIL simul_push_pop ready=%b count=%0d want 1,1", ready, fifo_count);
    end
    wait_frames(3);
    checks++;
    if (rx_start.size() < 3 || rx_start[2] - rx_start[1] != FRAME + 1) begin
      failures++;
      $display("FAIL simul_gap frames=%0d want back-to-back gap %0d", rx_start.size(), FRAME + 1);
    end
    check_rx("simul_first", x);
    check_rx("simul_0x11", 8'h11);
    check_rx("simul_0x55", 8'h55);
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold_valid();
    test_back_to_back();
    test_reset_midframe();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
